// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, ALUOp codes, funct codes
// and the ID/EX stage payload.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RIDX_W  = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned CTL_W   = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FUNCT_W = 6;

    typedef enum logic [CTL_W-1:0] {
        CTL_AND = 3'b000,
        CTL_OR  = 3'b001,
        CTL_ADD = 3'b010,
        CTL_SUB = 3'b110,
        CTL_SLT = 3'b111
    } alu_ctl_e;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ORI   = 2'b11
    } aluop_e;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    // Registered ID/EX payload; all-zero is both the reset value and a bubble.
    typedef struct packed {
        logic              valid;
        logic [CTL_W-1:0]  alu_ctl;
        logic              illegal;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [RIDX_W-1:0] rs;
        logic [RIDX_W-1:0] rt;
        logic [RIDX_W-1:0] dest;
        logic              alusrc;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
    } id_ex_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// ALU control decode: ALUOp plus R-type funct to the 3-bit ALU control code,
// flagging unsupported R-type functs.
module alu_ctl_decode
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] ctl,
    output logic       illegal
);

    always_comb begin
        ctl     = CTL_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: ctl = CTL_ADD;
            ALUOP_SUB: ctl = CTL_SUB;
            ALUOP_ORI: ctl = CTL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctl = CTL_ADD;
                    FUNCT_SUB: ctl = CTL_SUB;
                    FUNCT_AND: ctl = CTL_AND;
                    FUNCT_OR:  ctl = CTL_OR;
                    FUNCT_SLT: ctl = CTL_SLT;
                    default: begin
                        ctl     = CTL_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: ctl = CTL_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, immediate extension and
// EX/MEM, MEM/WB operand forwarding feeding the 32-bit ALU.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_aluop,
    input  logic [5:0]  id_funct,
    input  logic        id_alusrc,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [2:0]  ex_alu_ctl,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_dest,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_illegal
);

    logic [CTL_W-1:0] dec_ctl;
    logic             dec_illegal;
    id_ex_t           nxt;
    id_ex_t           cur;
    logic [XLEN-1:0]  fwd_rs;
    logic [XLEN-1:0]  fwd_rt;

    alu_ctl_decode u_alu_ctl_decode (
        .aluop   (id_aluop),
        .funct   (id_funct),
        .ctl     (dec_ctl),
        .illegal (dec_illegal)
    );

    // Next payload from ID; an illegal funct must never write the register file.
    always_comb begin
        nxt          = '0;
        nxt.valid    = id_valid;
        nxt.alu_ctl  = dec_ctl;
        nxt.illegal  = dec_illegal;
        nxt.rs_data  = id_rs_data;
        nxt.rt_data  = id_rt_data;
        nxt.imm      = (id_aluop == ALUOP_ORI) ? {16'h0000, id_imm}
                                               : {{16{id_imm[IMM_W-1]}}, id_imm};
        nxt.rs       = id_rs;
        nxt.rt       = id_rt;
        nxt.dest     = id_regdst ? id_rd : id_rt;
        nxt.alusrc   = id_alusrc;
        nxt.regwrite = id_regwrite & ~dec_illegal;
        nxt.memread  = id_memread;
        nxt.memwrite = id_memwrite;
        nxt.memtoreg = id_memtoreg;
    end

    // Stage register: reset, then flush (bubble), then stall (hold).
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else if (flush) begin
            cur <= '0;
        end else if (!stall) begin
            cur <= nxt;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB; register $0 is never forwarded.
    always_comb begin
        fwd_rs = cur.rs_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == cur.rs)) begin
            fwd_rs = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == cur.rs)) begin
            fwd_rs = memwb_result;
        end

        fwd_rt = cur.rt_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == cur.rt)) begin
            fwd_rt = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == cur.rt)) begin
            fwd_rt = memwb_result;
        end
    end

    assign ex_valid      = cur.valid;
    assign ex_alu_ctl    = cur.alu_ctl;
    assign ex_illegal    = cur.illegal;
    assign ex_a          = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_b          = cur.alusrc ? cur.imm : fwd_rt;
    assign ex_dest       = cur.dest;
    assign ex_regwrite   = cur.regwrite;
    assign ex_memread    = cur.memread;
    assign ex_memwrite   = cur.memwrite;
    assign ex_memtoreg   = cur.memtoreg;

endmodule
